// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the single regfile write port between NUM_REQ
// writeback sources, with a registered output stage, x0-write drop and a contention counter.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 16,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd_addr_i,
  input  logic [NUM_REQ*XLEN-1:0]   req_data_i,
  output logic                      write_en_o,
  output logic [ADDR_W-1:0]         rd_addr_o,
  output logic [XLEN-1:0]           write_data_o,
  output logic [ID_W-1:0]           grant_id_o,
  output logic [CNT_W-1:0]          conflict_cnt_o
);

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [XLEN-1:0]   data_arr [NUM_REQ];

  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              write_en_q, write_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]   write_data_q, write_data_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic              xfer;
  logic              multi_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]    = req_rd_addr_i[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi]    = req_data_i[gi*XLEN +: XLEN];
      assign req_ready_o[gi] = xfer && (grant_idx == ID_W'(gi));
    end
  endgenerate

  // Search starts at rr_ptr and wraps explicitly so non-power-of-2 counts never
  // produce an out-of-range index.
  always_comb begin : arbitrate
    logic [ID_W:0] cand;
    cand      = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_vld && req_valid_i[cand[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
  end

  assign xfer        = grant_vld && !flush_i && rst_n;
  assign multi_valid = |(req_valid_i & (req_valid_i - NUM_REQ'(1)));

  always_comb begin : next_state
    rr_ptr_d       = rr_ptr_q;
    write_en_d     = 1'b0;
    rd_addr_d      = rd_addr_q;
    write_data_d   = write_data_q;
    grant_id_d     = grant_id_q;
    conflict_cnt_d = conflict_cnt_q;
    if (xfer) begin
      // x0 writes are consumed but never reach the regfile
      write_en_d   = |addr_arr[grant_idx];
      rd_addr_d    = addr_arr[grant_idx];
      write_data_d = data_arr[grant_idx];
      grant_id_d   = grant_idx;
      rr_ptr_d     = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
    if (multi_valid && !flush_i && !(&conflict_cnt_q)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q       <= '0;
      write_en_q     <= 1'b0;
      rd_addr_q      <= '0;
      write_data_q   <= '0;
      grant_id_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      write_en_q     <= write_en_d;
      rd_addr_q      <= rd_addr_d;
      write_data_q   <= write_data_d;
      grant_id_q     <= grant_id_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign write_en_o     = write_en_q;
  assign rd_addr_o      = rd_addr_q;
  assign write_data_o   = write_data_q;
  assign grant_id_o     = grant_id_q;
  assign conflict_cnt_o = conflict_cnt_q;

endmodule
